cr_xp10_decomp_hdr_bitbuf: RTL and testbench
============================================

# cr_xp10_decomp_hdr_bitbuf

Parametrised header bit buffer for the XP10 decompressor header path. Accepts DP_WIDTH-bit header words from the block-header parser over a valid/ready channel, buffers them in a flop FIFO of configurable depth, and presents up to OUT_BITS bits per cycle LSB-first to the Huffman-table-format decoder. It adds byte-alignment skip, a per-frame consumed-bit counter, and a discard-to-end-of-frame mode after a mid-frame clear.

## Interface
- DP_WIDTH, 64, input word width in bits; must be at least OUT_BITS.
- OUT_BITS, 16, maximum bits presented and consumed per cycle.
- DEPTH, 4, FIFO depth in words; must be at least 2.
- CNT_W, 20, width of the frame bit counter.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high, single clock domain.
- in_valid  in  1  word valid.
- in_data  in  DP_WIDTH  header word; bit 0 is the first bit.
- in_last  in  1  last word of the frame.
- in_trace  in  1  trace bit for the stall strobe.
- in_ready  out  1  word accepted when in_valid && in_ready.
- bits_avail  out  $clog2(OUT_BITS+1)  valid bits in bits_data.
- bits_data  out  OUT_BITS  next bits, LSB-first; bits above bits_avail are 0.
- bits_last  out  1  all remaining frame bits are visible.
- bits_consume  in  $clog2(OUT_BITS+1)  bits to drop this cycle.
- align_req  in  1  drop bits up to the next byte boundary of frame_bit_cnt.
- bits_err  out  1  combinational; the requested drop exceeds bits_avail.
- hdr_clear  in  1  flush the buffer and end the frame.
- frame_bit_cnt  out  CNT_W  bits consumed since the last clear; saturates at all-ones.
- stall_stb  out  1  registered trace stall strobe.

## Operation
- The datapath is a DEPTH-word FIFO feeding an accumulator `acc` of ACC_W = DP_WIDTH+OUT_BITS bits, with fill count `fill` and flag `acc_last`.
- Drop amount per cycle:
  - With align_req, `req` = (8 − frame_bit_cnt[2:0]) mod 8 and bits_consume is ignored.
  - Otherwise `req` = bits_consume.
  - `drop` = min(req, bits_avail).
  - bits_err = (req > bits_avail).
- Accumulator update:
  - `acc` shifts right by `drop` and `fill` decreases by `drop`.
  - When the FIFO is not empty, !acc_last, and fill−drop < OUT_BITS, the head word is popped. It is placed at bit position fill−drop, `fill` increases by DP_WIDTH, and acc_last is set to the stored last bit of that word.
- bits_avail = min(fill, OUT_BITS).
- bits_last = acc_last && fill ≤ OUT_BITS. It stays asserted, including at bits_avail = 0, until hdr_clear.
- frame_bit_cnt increases by `drop` each cycle, saturates at all-ones, and clears on hdr_clear.
- Write-side state machine:
  - FILL: in_ready = !full. An accepted word is written to the FIFO. An accepted word with in_last moves the machine to WAIT.
  - WAIT: in_ready = 0 until hdr_clear.
  - DISCARD: in_ready = 1. Accepted words are dropped. An accepted word with in_last moves the machine to FILL.
- hdr_clear:
  - Empties the FIFO and the accumulator and clears acc_last and frame_bit_cnt.
  - Next state is FILL from WAIT and DISCARD from FILL.
  - If the machine is in DISCARD, it stays in DISCARD; an in_last accepted in the same cycle moves it to FILL.
  - An in_last word accepted in FILL in the same cycle as hdr_clear is not written, and the machine moves to FILL.
  - Any drop, pop or write in the clear cycle is suppressed.
- stall_stb (registered) = in_valid && !in_ready && in_trace.

## Timing
- While rst is high, in_ready = 0; on the first cycle after rst deasserts, in_ready = 1.
- Reset values: bits_avail = 0, bits_data = 0, bits_last = 0, frame_bit_cnt = 0, stall_stb = 0, state = FILL, FIFO empty.
- Latency: a word accepted at edge N is in the FIFO from cycle N+1, popped at edge N+1, and visible in bits_avail and bits_data in cycle N+2.
- Throughput: one word per cycle in, OUT_BITS bits per cycle out.
- Simultaneous write and pop on a full FIFO: in_ready depends only on full, so there is no write-through when full.
- Consume and outputs: bits_consume and align_req act on the bits visible in the same cycle. Outputs reflect the drop from the next cycle.
- stall_stb lags the stalled cycle by one cycle.

## Structure
- Shared decompressor package holds:
  - `hdr_bitbuf_state_e` with values FILL, WAIT and DISCARD.
  - The default `N_HTF_HDR_BITBUF_DEPTH`.
- Sub-module `cr_xp10_decomp_hdr_word_fifo`:
  - Flop FIFO of DEPTH × (DP_WIDTH+1) bits, holding the data and the last flag.
  - Combinational head read.
  - Ports: full, empty, wen, ren, clear.
- Accumulator, drop logic, counter and state machine live in the top level.

## Test plan
- Reset then one word 0x...0001_ABCD with in_last and consume 16 per cycle:
  - bits_data = 0xABCD in cycle N+2.
  - bits_last rises when fill ≤ 16.
  - frame_bit_cnt reaches 64.
- Consume 3 on a stream, then align_req:
  - Drop is 5 and frame_bit_cnt = 8.
  - With align_req at a count of 8, the drop is 0.
- bits_consume = 16 with bits_avail = 10 at the frame tail:
  - bits_err = 1, drop is 10, bits_avail = 0.
  - bits_last stays 1.
- DEPTH = 4 with no consume and 6 words offered:
  - in_ready falls after 4 FIFO writes plus 1 accumulator word.
  - stall_stb pulses only on stalled cycles with in_trace = 1.
- hdr_clear after 2 of 5 words:
  - The remaining 3 words are accepted and dropped.
  - bits_avail stays 0.
  - The next frame appears intact.
- hdr_clear in the same cycle as an accepted in_last in FILL:
  - The word is dropped and the machine goes to FILL.
  - The next frame's first word is visible 2 cycles after acceptance.

Source files
------------

// File: rtl/cr_xp10_decomp_hdr_bitbuf_pkg.sv
// Shared types and defaults for the XP10 decompressor header bit buffer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cr_xp10_decomp_hdr_bitbuf_pkg;

    // Default FIFO depth in words for the Huffman-table-format header buffer
    localparam int N_HTF_HDR_BITBUF_DEPTH = 4;

    // Write-side state: accepting words, waiting for clear after last, or dropping a cut frame
    typedef enum logic [1:0] {
        FILL    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } hdr_bitbuf_state_e;

endpackage

// File: rtl/cr_xp10_decomp_hdr_word_fifo.sv
// Flop FIFO of DEPTH words, each word being header data plus its last flag.
// Latency: written word readable at the head one cycle after the write; head read is combinational.
// Backpressure: writes when full and reads when empty are ignored; clear empties it in one cycle.
module cr_xp10_decomp_hdr_word_fifo #(
    parameter int W     = 65,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         wen,
    input  logic [W-1:0] wdata,
    input  logic         ren,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [CW-1:0] cnt;
    logic          do_wr;
    logic          do_rd;

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign rdata = mem[rptr];
    assign do_wr = wen && !full && !clear;
    assign do_rd = ren && !empty && !clear;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // Pointer and occupancy bookkeeping; clear behaves like a reset of the control state
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wptr <= '0;
            rptr <= '0;
            cnt  <= '0;
        end else begin
            if (do_wr) wptr <= ptr_inc(wptr);
            if (do_rd) rptr <= ptr_inc(rptr);
            cnt <= cnt + CW'(do_wr) - CW'(do_rd);
        end
    end

    // Storage array, no reset needed since occupancy gates every read
    always_ff @(posedge clk) begin
        if (do_wr) mem[wptr] <= wdata;
    end

endmodule

// File: rtl/cr_xp10_decomp_hdr_bitbuf.sv
// Header bit buffer: DP_WIDTH-bit words in, up to OUT_BITS bits/cycle out LSB-first, with align skip and frame discard.
// Latency: word accepted at edge N is popped at edge N+1 and visible in cycle N+2.
// Backpressure: in_ready drops when the FIFO is full or after the frame's last word until hdr_clear.
module cr_xp10_decomp_hdr_bitbuf
    import cr_xp10_decomp_hdr_bitbuf_pkg::*;
#(
    parameter int DP_WIDTH = 64,
    parameter int OUT_BITS = 16,
    parameter int DEPTH    = N_HTF_HDR_BITBUF_DEPTH,
    parameter int CNT_W    = 20
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [DP_WIDTH-1:0]           in_data,
    input  logic                          in_last,
    input  logic                          in_trace,
    output logic                          in_ready,
    output logic [$clog2(OUT_BITS+1)-1:0] bits_avail,
    output logic [OUT_BITS-1:0]           bits_data,
    output logic                          bits_last,
    input  logic [$clog2(OUT_BITS+1)-1:0] bits_consume,
    input  logic                          align_req,
    output logic                          bits_err,
    input  logic                          hdr_clear,
    output logic [CNT_W-1:0]              frame_bit_cnt,
    output logic                          stall_stb
);
    localparam int ACC_W = DP_WIDTH + OUT_BITS;
    localparam int FW    = $clog2(ACC_W + 1);
    localparam int AV_W  = $clog2(OUT_BITS + 1);

    hdr_bitbuf_state_e state;
    hdr_bitbuf_state_e state_nx;

    logic [ACC_W-1:0]  acc;
    logic [FW-1:0]     fill;
    logic              acc_last;
    logic [FW-1:0]     fill_sh;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_wen;
    logic              fifo_ren;
    logic [DP_WIDTH:0] fifo_head;
    logic              in_acc;
    logic [2:0]        align_amt;
    logic [AV_W-1:0]   req;
    logic [AV_W-1:0]   drop;
    logic [CNT_W:0]    cnt_sum;

    cr_xp10_decomp_hdr_word_fifo #(
        .W     (DP_WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_word_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (hdr_clear),
        .wen   (fifo_wen),
        .wdata ({in_last, in_data}),
        .ren   (fifo_ren),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Output view: bits above fill are always zero in acc, so the low slice needs no mask
    assign bits_avail = (fill >= FW'(OUT_BITS)) ? AV_W'(OUT_BITS) : fill[AV_W-1:0];
    assign bits_data  = acc[OUT_BITS-1:0];
    assign bits_last  = acc_last && (fill <= FW'(OUT_BITS));

    // Align skips to the next byte boundary of the frame count; over-asks are clipped and flagged
    assign align_amt = 3'd0 - frame_bit_cnt[2:0];
    assign req       = align_req ? AV_W'(align_amt) : bits_consume;
    assign bits_err  = (req > bits_avail);
    assign drop      = hdr_clear ? '0 : (bits_err ? bits_avail : req);
    assign fill_sh   = fill - FW'(drop);

    // Refill only once the frame's last word has not yet been loaded and the window would run short
    assign fifo_ren = !fifo_empty && !acc_last && (fill_sh < FW'(OUT_BITS)) && !hdr_clear;

    assign in_ready = !rst && (((state == FILL) && !fifo_full) || (state == DISCARD));
    assign in_acc   = in_valid && in_ready;
    assign fifo_wen = in_acc && (state == FILL) && !hdr_clear;
    assign cnt_sum  = {1'b0, frame_bit_cnt} + (CNT_W + 1)'(drop);

    // Accumulator: shift out dropped bits, append the popped head word right above what remains
    always_ff @(posedge clk) begin
        if (rst || hdr_clear) begin
            acc      <= '0;
            fill     <= '0;
            acc_last <= 1'b0;
        end else if (fifo_ren) begin
            acc      <= (acc >> drop) | (ACC_W'(fifo_head[DP_WIDTH-1:0]) << fill_sh);
            fill     <= fill_sh + FW'(DP_WIDTH);
            acc_last <= fifo_head[DP_WIDTH];
        end else begin
            acc  <= acc >> drop;
            fill <= fill_sh;
        end
    end

    // Saturating count of bits consumed since the last clear
    always_ff @(posedge clk) begin
        if (rst || hdr_clear) begin
            frame_bit_cnt <= '0;
        end else begin
            frame_bit_cnt <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
        end
    end

    // Write-side state register
    always_ff @(posedge clk) begin
        if (rst) state <= FILL;
        else     state <= state_nx;
    end

    // Write-side next state: a clear mid-frame discards the rest of the frame's words
    always_comb begin
        state_nx = state;
        case (state)
            FILL: begin
                if (hdr_clear)                state_nx = (in_acc && in_last) ? FILL : DISCARD;
                else if (in_acc && in_last)   state_nx = WAIT;
            end
            WAIT: begin
                if (hdr_clear)                state_nx = FILL;
            end
            DISCARD: begin
                if (in_acc && in_last)        state_nx = FILL;
            end
            default:                          state_nx = FILL;
        endcase
    end

    // Trace strobe for cycles where an offered word was held off
    always_ff @(posedge clk) begin
        if (rst) stall_stb <= 1'b0;
        else     stall_stb <= in_valid && !in_ready && in_trace;
    end

endmodule

// File: tb/tb_cr_xp10_decomp_hdr_bitbuf.sv
// Self-checking bench for the header bit buffer.
// Inputs driven on the falling edge, outputs sampled there too, expected bits kept in a bit queue.
// Each scenario task performs its own comparisons; one summary line at the end.
module tb_cr_xp10_decomp_hdr_bitbuf;
    localparam int DPW = 64;
    localparam int OB  = 16;
    localparam int DEP = 4;
    localparam int CW  = 20;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [DPW-1:0] in_data;
    logic          in_last;
    logic          in_trace;
    logic          in_ready;
    logic [4:0]    bits_avail;
    logic [OB-1:0] bits_data;
    logic          bits_last;
    logic [4:0]    bits_consume;
    logic          align_req;
    logic          bits_err;
    logic          hdr_clear;
    logic [CW-1:0] frame_bit_cnt;
    logic          stall_stb;

    int tests = 0;
    int fails = 0;
    bit sbq[$];
    int exp_cnt = 0;

    always #5 clk = ~clk;

    cr_xp10_decomp_hdr_bitbuf #(
        .DP_WIDTH (DPW),
        .OUT_BITS (OB),
        .DEPTH    (DEP),
        .CNT_W    (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_last       (in_last),
        .in_trace      (in_trace),
        .in_ready      (in_ready),
        .bits_avail    (bits_avail),
        .bits_data     (bits_data),
        .bits_last     (bits_last),
        .bits_consume  (bits_consume),
        .align_req     (align_req),
        .bits_err      (bits_err),
        .hdr_clear     (hdr_clear),
        .frame_bit_cnt (frame_bit_cnt),
        .stall_stb     (stall_stb)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1);
    end

    task automatic push_word(input logic [DPW-1:0] w);
        for (int b = 0; b < DPW; b++) sbq.push_back(w[b]);
    endtask

    // Compare visible bits with the scoreboard head, then request a drop and retire the dropped bits
    task automatic step_out(input int cons, input bit align);
        logic [OB-1:0] exp;
        int av;
        int req;
        int drop;
        av  = int'(bits_avail);
        exp = '0;
        if (av > 0) begin
            for (int b = 0; b < av && b < OB; b++) if (b < sbq.size()) exp[b] = sbq[b];
            tests++;
            if (sbq.size() < av || bits_data !== exp) begin
                fails++;
                $display("FAIL data: got %h want %h (avail %0d, queued %0d)", bits_data, exp, av, sbq.size());
            end
        end
        req  = align ? ((8 - (exp_cnt % 8)) % 8) : cons;
        drop = (req > av) ? av : req;
        bits_consume = 5'(cons);
        align_req    = align;
        for (int b = 0; b < drop; b++) if (sbq.size() > 0) void'(sbq.pop_front());
        exp_cnt += drop;
    endtask

    task automatic drain(input int cons, input int max);
        int cyc = 0;
        while (cyc < max && !(bits_last === 1'b1 && bits_avail == 5'd0)) begin
            step_out(cons, 1'b0);
            @(negedge clk);
            cyc++;
        end
        bits_consume = '0;
        align_req    = 1'b0;
        tests++;
        if (cyc >= max || sbq.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d cycles, %0d bits left; want < %0d cycles, 0 left", cyc, sbq.size(), max);
        end
    endtask

    task automatic clear_frame();
        in_valid     = 1'b0;
        bits_consume = '0;
        align_req    = 1'b0;
        hdr_clear    = 1'b1;
        @(negedge clk);
        hdr_clear = 1'b0;
        sbq.delete();
        exp_cnt = 0;
        tests++;
        if (frame_bit_cnt !== '0) begin
            fails++;
            $display("FAIL clear_cnt: got %0d want 0", frame_bit_cnt);
        end
        tests++;
        if (bits_last !== 1'b0 || bits_avail !== 5'd0) begin
            fails++;
            $display("FAIL clear_out: got last %b avail %0d want 0 0", bits_last, bits_avail);
        end
    endtask

    task automatic stream_frame(input int n, input int cons);
        logic [DPW-1:0] w[$];
        int sent = 0;
        int cyc  = 0;
        for (int i = 0; i < n; i++) w.push_back({$urandom(), $urandom()});
        while (cyc < 500 && !(sent == n && bits_last === 1'b1 && bits_avail == 5'd0)) begin
            step_out(cons, 1'b0);
            if (sent < n) begin
                in_valid = 1'b1;
                in_data  = w[sent];
                in_last  = (sent == n - 1);
                if (in_ready) begin
                    push_word(w[sent]);
                    sent++;
                end
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid     = 1'b0;
        in_last      = 1'b0;
        bits_consume = '0;
        tests++;
        if (cyc >= 500 || sbq.size() != 0) begin
            fails++;
            $display("FAIL stream: got %0d cycles %0d bits left, want finish with 0 left", cyc, sbq.size());
        end
        tests++;
        if (frame_bit_cnt !== CW'(n * DPW)) begin
            fails++;
            $display("FAIL stream_cnt: got %0d want %0d", frame_bit_cnt, n * DPW);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_trace = 1'b0;
        bits_consume = '0; align_req = 1'b0; hdr_clear = 1'b0;
        repeat (3) @(negedge clk);
        tests++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL rst_ready: got %b want 0", in_ready); end
        tests++;
        if (bits_avail !== 5'd0 || bits_data !== '0) begin
            fails++; $display("FAIL rst_bits: got avail %0d data %h want 0 0", bits_avail, bits_data);
        end
        tests++;
        if (bits_last !== 1'b0 || frame_bit_cnt !== '0 || stall_stb !== 1'b0) begin
            fails++; $display("FAIL rst_misc: got last %b cnt %0d stb %b want 0 0 0", bits_last, frame_bit_cnt, stall_stb);
        end
        rst = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
        @(negedge clk);
    endtask

    task automatic test_single_word();
        logic [DPW-1:0] w;
        w = 64'h0000_0000_0001_ABCD;
        in_valid = 1'b1; in_data = w; in_last = 1'b1;
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL sw_ready: got %b want 1", in_ready); end
        push_word(w);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        tests++;
        if (bits_avail !== 5'd0) begin fails++; $display("FAIL sw_lat1: got avail %0d want 0", bits_avail); end
        @(negedge clk);
        tests++;
        if (bits_avail !== 5'd16 || bits_data !== 16'hABCD) begin
            fails++; $display("FAIL sw_lat2: got avail %0d data %h want 16 abcd", bits_avail, bits_data);
        end
        for (int k = 0; k < 4; k++) begin
            tests++;
            if (bits_last !== (k == 3)) begin
                fails++; $display("FAIL sw_last%0d: got %b want %b", k, bits_last, (k == 3));
            end
            step_out(16, 1'b0);
            @(negedge clk);
        end
        bits_consume = '0;
        tests++;
        if (bits_avail !== 5'd0 || bits_last !== 1'b1 || frame_bit_cnt !== 20'd64) begin
            fails++; $display("FAIL sw_end: got avail %0d last %b cnt %0d want 0 1 64", bits_avail, bits_last, frame_bit_cnt);
        end
        clear_frame();
    endtask

    task automatic test_align();
        logic [DPW-1:0] w0;
        logic [DPW-1:0] w1;
        w0 = {$urandom(), $urandom()};
        w1 = {$urandom(), $urandom()};
        in_valid = 1'b1; in_data = w0; in_last = 1'b0;
        push_word(w0);
        @(negedge clk);
        in_data = w1; in_last = 1'b1;
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL al_ready: got %b want 1", in_ready); end
        push_word(w1);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        step_out(3, 1'b0);
        @(negedge clk);
        tests++;
        if (frame_bit_cnt !== 20'd3) begin fails++; $display("FAIL al_cnt3: got %0d want 3", frame_bit_cnt); end
        step_out(0, 1'b1);
        #1;
        tests++;
        if (bits_err !== 1'b0) begin fails++; $display("FAIL al_err: got %b want 0", bits_err); end
        @(negedge clk);
        tests++;
        if (frame_bit_cnt !== 20'd8) begin fails++; $display("FAIL al_cnt8: got %0d want 8", frame_bit_cnt); end
        step_out(0, 1'b1);
        @(negedge clk);
        tests++;
        if (frame_bit_cnt !== 20'd8) begin fails++; $display("FAIL al_noop: got %0d want 8", frame_bit_cnt); end
        align_req = 1'b0;
        drain(16, 40);
        tests++;
        if (frame_bit_cnt !== 20'd128) begin fails++; $display("FAIL al_total: got %0d want 128", frame_bit_cnt); end
        clear_frame();
    endtask

    task automatic test_err_tail();
        logic [DPW-1:0] w;
        w = {$urandom(), $urandom()};
        in_valid = 1'b1; in_data = w; in_last = 1'b1;
        push_word(w);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin step_out(16, 1'b0); @(negedge clk); end
        step_out(6, 1'b0);
        @(negedge clk);
        tests++;
        if (bits_avail !== 5'd10) begin fails++; $display("FAIL et_avail: got %0d want 10", bits_avail); end
        step_out(16, 1'b0);
        #1;
        tests++;
        if (bits_err !== 1'b1) begin fails++; $display("FAIL et_err: got %b want 1", bits_err); end
        @(negedge clk);
        bits_consume = '0;
        #1;
        tests++;
        if (bits_avail !== 5'd0 || bits_last !== 1'b1 || frame_bit_cnt !== 20'd64 || bits_err !== 1'b0) begin
            fails++; $display("FAIL et_end: got avail %0d last %b cnt %0d err %b want 0 1 64 0",
                              bits_avail, bits_last, frame_bit_cnt, bits_err);
        end
        @(negedge clk);
        clear_frame();
    endtask

    task automatic test_backpressure();
        logic [DPW-1:0] w[6];
        int  sent = 0;
        int  cyc  = 0;
        bit  exp_stall = 1'b0;
        for (int i = 0; i < 6; i++) w[i] = {$urandom(), $urandom()};
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1; in_data = w[sent]; in_last = (sent == 5);
            in_trace = (c == 6) ? 1'b0 : 1'b1;
            tests++;
            if (in_ready !== (sent < 5)) begin
                fails++; $display("FAIL bp_ready%0d: got %b want %b", c, in_ready, (sent < 5));
            end
            tests++;
            if (stall_stb !== exp_stall) begin
                fails++; $display("FAIL bp_stall%0d: got %b want %b", c, stall_stb, exp_stall);
            end
            exp_stall = !(sent < 5) && in_trace;
            if (in_ready) begin push_word(w[sent]); sent++; end
            @(negedge clk);
        end
        tests++;
        if (stall_stb !== exp_stall) begin fails++; $display("FAIL bp_stall8: got %b want %b", stall_stb, exp_stall); end
        while (sent < 6 && cyc < 50) begin
            step_out(16, 1'b0);
            if (in_ready) begin push_word(w[sent]); sent++; end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0; in_last = 1'b0; in_trace = 1'b0;
        tests++;
        if (sent != 6) begin fails++; $display("FAIL bp_accept: got %0d words want 6", sent); end
        drain(16, 60);
        tests++;
        if (frame_bit_cnt !== 20'd384) begin fails++; $display("FAIL bp_cnt: got %0d want 384", frame_bit_cnt); end
        clear_frame();
    endtask

    task automatic test_clear_mid();
        logic [DPW-1:0] w[5];
        for (int i = 0; i < 5; i++) w[i] = {$urandom(), $urandom()};
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_data = w[i]; in_last = 1'b0;
            @(negedge clk);
        end
        in_valid  = 1'b0;
        hdr_clear = 1'b1;
        @(negedge clk);
        hdr_clear = 1'b0;
        sbq.delete();
        exp_cnt = 0;
        for (int i = 2; i < 5; i++) begin
            in_valid = 1'b1; in_data = w[i]; in_last = (i == 4);
            tests++;
            if (in_ready !== 1'b1 || bits_avail !== 5'd0) begin
                fails++; $display("FAIL cm_discard%0d: got ready %b avail %0d want 1 0", i, in_ready, bits_avail);
            end
            @(negedge clk);
        end
        in_valid = 1'b0; in_last = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tests++;
            if (bits_avail !== 5'd0) begin fails++; $display("FAIL cm_idle%0d: got avail %0d want 0", k, bits_avail); end
            @(negedge clk);
        end
        stream_frame(2, 16);
        clear_frame();
    endtask

    task automatic test_clear_last();
        logic [DPW-1:0] w;
        w = {$urandom(), $urandom()};
        in_valid = 1'b1; in_data = ~w; in_last = 1'b1; hdr_clear = 1'b1;
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL cl_ready: got %b want 1", in_ready); end
        @(negedge clk);
        hdr_clear = 1'b0;
        sbq.delete();
        exp_cnt = 0;
        in_data = w; in_last = 1'b1;
        tests++;
        if (in_ready !== 1'b1) begin fails++; $display("FAIL cl_ready2: got %b want 1", in_ready); end
        push_word(w);
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        tests++;
        if (bits_avail !== 5'd0) begin fails++; $display("FAIL cl_lat1: got avail %0d want 0", bits_avail); end
        @(negedge clk);
        tests++;
        if (bits_avail !== 5'd16 || bits_data !== w[15:0]) begin
            fails++; $display("FAIL cl_lat2: got avail %0d data %h want 16 %h", bits_avail, bits_data, w[15:0]);
        end
        drain(16, 20);
        tests++;
        if (frame_bit_cnt !== 20'd64) begin fails++; $display("FAIL cl_cnt: got %0d want 64", frame_bit_cnt); end
        clear_frame();
    endtask

    task automatic test_back_to_back();
        stream_frame(4, 16);
        clear_frame();
        stream_frame(3, 7);
        clear_frame();
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_align();
        test_err_tail();
        test_backpressure();
        test_clear_mid();
        test_clear_last();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
